branch_target_predictor: RTL
============================

# branch_target_predictor

Parametrised direct-mapped branch target buffer with tag compare and per-entry 2-bit saturating direction counters, replacing the untagged, always-taken 16-entry table. Fetch performs a same-cycle lookup on the full PC and gets hit, predicted direction and target. Execute writes back the resolved branch outcome, which allocates entries and trains the counters. A flush input and saturating hit/allocation counters support pipeline recovery and performance measurement.

## Interface
- ADDR_W, 32: PC and target width.
- IDX_W, 4: index bits; ENTRIES = 2**IDX_W.
- TAG_W, 8: tag bits; IDX_W+TAG_W+2 <= ADDR_W required.
- CNT_W, 16: performance counter width.
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- lookup_en  in  1  fetch lookup is valid this cycle; only gates cnt_hit.
- lookup_pc  in  ADDR_W  fetch PC.
- pred_hit  out  1  valid entry with matching tag.
- pred_taken  out  1  pred_hit & counter[1].
- pred_target  out  ADDR_W  stored target; 0 when pred_hit=0.
- update_en  in  1  resolved branch from execute.
- update_pc  in  ADDR_W  PC of resolved branch.
- update_taken  in  1  resolved direction.
- update_target  in  ADDR_W  resolved target.
- flush  in  1  invalidate all entries.
- cnt_hit  out  CNT_W  lookups with lookup_en=1 and pred_hit=1, saturating.
- cnt_alloc  out  CNT_W  allocations performed, saturating.

## Operation
- Index = pc[IDX_W+1:2].
- Tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- Entry fields: valid (flop), tag, target, ctr[1:0]. Only valid must be reset.
- Lookup is combinational from table state: pred_hit = valid[idx] & (tag[idx]==lookup tag).
- Update, evaluated at the update index:
  - Hit, taken: ctr = min(ctr+1, 3); target <= update_target.
  - Hit, not taken: ctr = max(ctr-1, 0); target unchanged.
  - Miss, taken: allocate. valid=1, tag written, target written, ctr=2'b10 (weakly taken), cnt_alloc+1. The previous occupant is overwritten unconditionally.
  - Miss, not taken: no state change.
- Counters saturate at all-ones and never wrap.
- Priority: reset > flush > update.
  - Flush clears all valid bits in one cycle and discards a same-cycle update.
  - Flush does not clear cnt_hit or cnt_alloc.
- Reset clears every valid bit, cnt_hit and cnt_alloc. It also aborts any same-cycle update or flush.

## Timing
- Lookup latency 0: outputs are a function of lookup_pc and current state.
- Update latency 1: the write lands at the clock edge and is visible to lookups from the next cycle.
- Same-cycle update and lookup to the same index: the lookup sees pre-update contents. There is no bypass.
- Flush asserted in cycle N: pred_hit=0 for every PC in cycle N+1 until re-allocation.
- Reset values:
  - pred_hit=0, pred_taken=0, pred_target=0 for every PC.
  - cnt_hit=0, cnt_alloc=0.
- Reset asserted mid-sequence takes effect at that edge. No partial state survives.
- cnt_hit increments at the edge after a qualifying lookup cycle.

## Test plan
Use defaults. PC 0x40 gives index 0, tag 1; PC 0x440 gives index 0, tag 0x11.
- Reset, then lookup 0x40 -> pred_hit=0, pred_taken=0, pred_target=0, cnt_hit=0, cnt_alloc=0.
- Update 0x40 taken, target 0x100; next cycle lookup 0x40 -> hit=1, taken=1, target=0x100, cnt_alloc=1. Lookup 0x440 -> hit=0 (tag mismatch).
- Counter training on the 0x40 entry:
  - Two not-taken updates -> ctr 2→1→0, pred_taken=0, hit=1.
  - Third not-taken update -> ctr stays 0.
  - Then three taken updates with target 0x200 -> ctr 1,2,3; taken=1; target=0x200.
- Update 0x440 taken, target 0x300 -> entry replaced. Lookup 0x40 -> miss; 0x440 -> target 0x300; cnt_alloc=2.
  - Not-taken update to a missing PC -> no allocation, cnt_alloc unchanged.
- Boundary cases:
  - Update and lookup of 0x40 in the same cycle -> lookup shows old state; new state appears next cycle.
  - Flush plus update in the same cycle -> all entries invalid and update discarded; cnt values retained.
- Saturation: with CNT_W=2, four hitting lookups -> cnt_hit = 3 and holds. Reset mid-stream -> all outputs return to the reset values.

Source files
------------

// File: rtl/branch_target_predictor.sv
// Direct-mapped, tagged branch target buffer with 2-bit direction counters and saturating perf counters.
// Lookup is combinational (0 cycles); an update lands at the next edge; the block is always ready (no backpressure).
module branch_target_predictor #(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lookup_en,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              update_en,
  input  logic [ADDR_W-1:0] update_pc,
  input  logic              update_taken,
  input  logic [ADDR_W-1:0] update_target,
  input  logic              flush,
  output logic [CNT_W-1:0]  cnt_hit,
  output logic [CNT_W-1:0]  cnt_alloc
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [ADDR_W-1:0]  target_mem [ENTRIES];
  logic [1:0]         ctr_mem    [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             up_write;
  logic             alloc;
  logic             unused_pc_bits;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign up_idx = update_pc[IDX_W+1:2];
  assign up_tag = update_pc[IDX_W+TAG_W+1:IDX_W+2];

  // Byte-offset and high PC bits do not take part in indexing or tagging.
  assign unused_pc_bits = ^{lookup_pc, update_pc};

  assign pred_hit    = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign pred_taken  = pred_hit && ctr_mem[lk_idx][1];
  assign pred_target = pred_hit ? target_mem[lk_idx] : '0;

  assign up_hit   = valid[up_idx] && (tag_mem[up_idx] == up_tag);
  assign up_write = update_en && !flush && !reset;
  assign alloc    = up_write && !up_hit && update_taken;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      valid <= '0;
    end else if (alloc) begin
      valid[up_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: it is only observed through a valid bit.
  always_ff @(posedge clk) begin
    if (up_write) begin
      if (up_hit) begin
        if (update_taken) begin
          if (ctr_mem[up_idx] != 2'b11) ctr_mem[up_idx] <= ctr_mem[up_idx] + 2'd1;
          target_mem[up_idx] <= update_target;
        end else if (ctr_mem[up_idx] != 2'b00) begin
          ctr_mem[up_idx] <= ctr_mem[up_idx] - 2'd1;
        end
      end else if (update_taken) begin
        tag_mem[up_idx]    <= up_tag;
        target_mem[up_idx] <= update_target;
        ctr_mem[up_idx]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_hit   <= '0;
      cnt_alloc <= '0;
    end else begin
      if (lookup_en && pred_hit && (cnt_hit != '1)) cnt_hit <= cnt_hit + CNT_W'(1);
      if (alloc && (cnt_alloc != '1)) cnt_alloc <= cnt_alloc + CNT_W'(1);
    end
  end

endmodule
